// File: rtl/b14_mem_responder.sv
// Memory target for the b14 processor bus: registered reads, store writes, load port and access counters.
// Optional write protection of the low WP_LIMIT words is enabled by defining MEM_WPROT_EN.
module b14_mem_responder #(
  parameter int DEPTH    = 1024,
  parameter int WP_LIMIT = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] addr,
  input  logic [30:0] datao,
  input  logic        rd,
  input  logic        wr,
  output logic [30:0] datai,
  output logic        busy,
  output logic        oor_err,
  output logic        wp_err,
  input  logic        ld_en,
  input  logic [19:0] ld_addr,
  input  logic [30:0] ld_data,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int          AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [20:0] DEPTH_W  = 21'(DEPTH);
  localparam logic [20:0] WP_W     = 21'(WP_LIMIT);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

`ifdef MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q;
  logic [30:0]     mem [DEPTH];

  logic            in_range;
  logic            wp_block;
  logic            wr_ok;
  logic            ld_ok;
  logic            ld_hit;
  logic [AW-1:0]   bus_idx;
  logic [AW-1:0]   ld_idx;
  logic [30:0]     rd_data;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    busy     = (state_q == CLEAR);
    in_range = ({1'b0, addr} < DEPTH_W);
    bus_idx  = addr[AW-1:0];
    ld_idx   = ld_addr[AW-1:0];
    wp_block = 1'b0;
    wr_ok    = 1'b0;
    ld_ok    = 1'b0;
    ld_hit   = 1'b0;
    rd_data  = '0;
    case (state_q)
      CLEAR: begin
        if (ptr_q == PTR_LAST) state_d = READY;
      end
      READY: begin
        wp_block = WPROT && wr && in_range && ({1'b0, addr} < WP_W);
        wr_ok    = wr && in_range && !wp_block;
        ld_ok    = ld_en && ({1'b0, ld_addr} < DEPTH_W);
        ld_hit   = ld_ok && (ld_addr == addr);
        // Write-first forwarding: the load beats the bus write, which beats stored data.
        if (!in_range)   rd_data = '0;
        else if (ld_hit) rd_data = ld_data;
        else if (wr_ok)  rd_data = datao;
        else             rd_data = mem[bus_idx];
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      datai   <= '0;
      oor_err <= 1'b0;
      wp_err  <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      state_q <= state_d;
      oor_err <= 1'b0;
      wp_err  <= 1'b0;
      if (state_q == CLEAR) begin
        ptr_q <= ptr_q + AW'(1);
      end else begin
        if (rd) datai <= rd_data;
        oor_err <= (rd || wr) && !in_range;
        wp_err  <= wp_block;
        if (rd && in_range && rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 16'd1;
        if (wr_ok && wr_cnt != CNT_MAX)          wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

  // NOTE: the array has no reset term; the CLEAR sweep zeroes it one word per cycle instead.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state_q == CLEAR) begin
        mem[ptr_q] <= '0;
      end else begin
        // Load is assigned last so it overrides a bus write to the same word.
        if (wr_ok) mem[bus_idx] <= datao;
        if (ld_ok) mem[ld_idx]  <= ld_data;
      end
    end
  end

endmodule
